trace_stream_receiver: RTL and testbench

Receiving end of the trace AXI-Stream produced by the continuous monitoring system. Accepts `{instr, clk_counter_delta, pc}` beats on an AXI-Stream slave port and unpacks them. Rebuilds an absolute cycle timestamp from the per-packet deltas and presents each decoded record on a valid/ready output interface. Sits on the PL side between the trace DMA/loopback path and on-chip consumers such as checkers and the stats block.

---
 rtl/trace_pkg.sv | 25 ++
 rtl/axis_skid_buffer.sv | 73 +++++++
 rtl/trace_stream_receiver.sv | 160 ++++++++++++++++
 tb/tb_trace_stream_receiver.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trace_pkg.sv
// Constants shared by the trace stream transmitter and receiver: beat layout,
// WFI encoding and receiver state encoding.
package trace_pkg;

  localparam int unsigned CLK_COUNTER_WIDTH = 64;
  localparam int unsigned INSTR_WIDTH       = 32;
  localparam int unsigned PC_LSB            = 0;
  localparam logic [31:0] WFI_INSTRUCTION   = 32'h1050_0073;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_ENDED = 2'd2
  } trace_state_e;

  // Beat layout is {instr, delta, pc} from MSB to LSB.
  function automatic int unsigned delta_lsb(input int unsigned xlen);
    return xlen;
  endfunction

  function automatic int unsigned instr_lsb(input int unsigned xlen, input int unsigned ts_width);
    return xlen + ts_width;
  endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry valid/ready buffer (output register plus one skid register);
// the skid entry always drains ahead of new input so ordering is kept.
module axis_skid_buffer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic             skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0] skid_data_q,  skid_data_d;
  logic             accept;
  logic             load_out;

  assign in_ready = ~skid_valid_q & ~clear;
  assign accept   = in_valid & in_ready;
  assign load_out = ~out_valid_q | out_ready;

  // Output register refills from skid first, then from the input.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (clear) begin
      out_valid_d  = 1'b0;
      out_data_d   = '0;
      skid_valid_d = 1'b0;
      skid_data_d  = '0;
    end else if (load_out) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = accept;
        if (accept) begin
          out_data_d = in_data;
        end
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_data_d  = in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: rtl/trace_stream_receiver.sv
// Trace AXI-Stream receiver: unpacks {instr, delta, pc} beats, rebuilds the
// absolute timestamp and tracks run state. Stats logic under TRACE_RX_STATS_EN.
module trace_stream_receiver
  import trace_pkg::*;
#(
  parameter int unsigned XLEN           = 64,
  parameter int unsigned TS_WIDTH       = CLK_COUNTER_WIDTH,
  parameter int unsigned AXI_DATA_WIDTH = XLEN + INSTR_WIDTH + TS_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      S_AXIS_tvalid,
  output logic                      S_AXIS_tready,
  input  logic [AXI_DATA_WIDTH-1:0] S_AXIS_tdata,
  input  logic                      S_AXIS_tlast,
  input  logic                      clear,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [XLEN-1:0]           out_pc,
  output logic [31:0]               out_instr,
  output logic [TS_WIDTH-1:0]       out_delta,
  output logic [TS_WIDTH-1:0]       out_timestamp,
  output logic                      out_last,
  output logic                      out_wfi,
  output logic [1:0]                state,
  output logic [31:0]               pkt_count,
  output logic [31:0]               frame_count,
  output logic                      delta_err
);

  localparam int unsigned DELTA_LSB = delta_lsb(XLEN);
  localparam int unsigned INSTR_LSB = instr_lsb(XLEN, TS_WIDTH);
  localparam int unsigned P_TS_LSB    = 0;
  localparam int unsigned P_PC_LSB    = TS_WIDTH;
  localparam int unsigned P_DELTA_LSB = TS_WIDTH + XLEN;
  localparam int unsigned P_INSTR_LSB = 2 * TS_WIDTH + XLEN;
  localparam int unsigned P_LAST      = P_INSTR_LSB + INSTR_WIDTH;
  localparam int unsigned P_WFI       = P_LAST + 1;
  localparam int unsigned PAYLOAD_W   = P_WFI + 1;

  logic [XLEN-1:0]        beat_pc;
  logic [TS_WIDTH-1:0]    beat_delta;
  logic [INSTR_WIDTH-1:0] beat_instr;
  logic                   beat_wfi;
  logic                   accept;
  logic [TS_WIDTH-1:0]    ts_q, ts_d, ts_new;
  trace_state_e           state_q, state_d;
  logic [PAYLOAD_W-1:0]   payload_in, payload_out;

  assign beat_pc    = S_AXIS_tdata[PC_LSB +: XLEN];
  assign beat_delta = S_AXIS_tdata[DELTA_LSB +: TS_WIDTH];
  assign beat_instr = S_AXIS_tdata[INSTR_LSB +: INSTR_WIDTH];
  assign beat_wfi   = (beat_instr == WFI_INSTRUCTION);
  assign accept     = S_AXIS_tvalid & S_AXIS_tready;

  // The first beat after reset/clear re-bases the accumulator; later beats add.
  assign ts_new = (state_q == ST_IDLE) ? beat_delta : ts_q + beat_delta;

  always_comb begin
    ts_d    = ts_q;
    state_d = state_q;
    if (clear) begin
      ts_d    = '0;
      state_d = ST_IDLE;
    end else if (accept) begin
      ts_d = ts_new;
      case (state_q)
        ST_IDLE:  state_d = beat_wfi ? ST_ENDED : ST_RUN;
        ST_RUN:   state_d = beat_wfi ? ST_ENDED : ST_RUN;
        ST_ENDED: state_d = beat_wfi ? ST_ENDED : ST_RUN;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_q    <= '0;
      state_q <= ST_IDLE;
    end else begin
      ts_q    <= ts_d;
      state_q <= state_d;
    end
  end

  assign payload_in = {beat_wfi, S_AXIS_tlast, beat_instr, beat_delta, beat_pc, ts_new};

  axis_skid_buffer #(
    .WIDTH (PAYLOAD_W)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (S_AXIS_tvalid),
    .in_ready  (S_AXIS_tready),
    .in_data   (payload_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (payload_out)
  );

  assign out_timestamp = payload_out[P_TS_LSB +: TS_WIDTH];
  assign out_pc        = payload_out[P_PC_LSB +: XLEN];
  assign out_delta     = payload_out[P_DELTA_LSB +: TS_WIDTH];
  assign out_instr     = payload_out[P_INSTR_LSB +: INSTR_WIDTH];
  assign out_last      = payload_out[P_LAST];
  assign out_wfi       = payload_out[P_WFI];
  assign state         = state_q;

`ifdef TRACE_RX_STATS_EN
  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  logic [31:0] pkt_count_q,   pkt_count_d;
  logic [31:0] frame_count_q, frame_count_d;
  logic        delta_err_q,   delta_err_d;

  // Saturating beat/frame counters and sticky zero-delta flag.
  always_comb begin
    pkt_count_d   = pkt_count_q;
    frame_count_d = frame_count_q;
    delta_err_d   = delta_err_q;
    if (clear) begin
      pkt_count_d   = '0;
      frame_count_d = '0;
      delta_err_d   = 1'b0;
    end else if (accept) begin
      if (pkt_count_q != CNT_MAX) begin
        pkt_count_d = pkt_count_q + 32'd1;
      end
      if (S_AXIS_tlast && (frame_count_q != CNT_MAX)) begin
        frame_count_d = frame_count_q + 32'd1;
      end
      if ((state_q != ST_IDLE) && (beat_delta == '0)) begin
        delta_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_count_q   <= '0;
      frame_count_q <= '0;
      delta_err_q   <= 1'b0;
    end else begin
      pkt_count_q   <= pkt_count_d;
      frame_count_q <= frame_count_d;
      delta_err_q   <= delta_err_d;
    end
  end

  assign pkt_count   = pkt_count_q;
  assign frame_count = frame_count_q;
  assign delta_err   = delta_err_q;
`else
  assign pkt_count   = '0;
  assign frame_count = '0;
  assign delta_err   = 1'b0;
`endif

endmodule

// File: tb/tb_trace_stream_receiver.sv
// Bench for trace_stream_receiver: directed steps plus a random phase, all
// checked against a queue-based reference model of the receiver.
module tb_trace_stream_receiver;
  import trace_pkg::*;

`ifdef TRACE_RX_STATS_EN
  localparam bit STATS_EN = 1'b1;
`else
  localparam bit STATS_EN = 1'b0;
`endif
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         S_AXIS_tvalid = 1'b0;
  logic         S_AXIS_tready;
  logic [159:0] S_AXIS_tdata = '0;
  logic         S_AXIS_tlast = 1'b0;
  logic         clear = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [63:0]  out_pc;
  logic [31:0]  out_instr;
  logic [63:0]  out_delta;
  logic [63:0]  out_timestamp;
  logic         out_last;
  logic         out_wfi;
  logic [1:0]   state;
  logic [31:0]  pkt_count;
  logic [31:0]  frame_count;
  logic         delta_err;

  trace_stream_receiver dut (
    .clk(clk), .rst_n(rst_n),
    .S_AXIS_tvalid(S_AXIS_tvalid), .S_AXIS_tready(S_AXIS_tready),
    .S_AXIS_tdata(S_AXIS_tdata), .S_AXIS_tlast(S_AXIS_tlast),
    .clear(clear),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr), .out_delta(out_delta),
    .out_timestamp(out_timestamp), .out_last(out_last), .out_wfi(out_wfi),
    .state(state), .pkt_count(pkt_count), .frame_count(frame_count),
    .delta_err(delta_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
    logic [63:0] delta;
    logic [63:0] ts;
    logic        last;
    logic        wfi;
  } rec_t;

  rec_t        exp_q[$];
  logic [63:0] m_ts;
  bit          m_first;
  logic [1:0]  m_state;
  logic [31:0] m_pkts;
  logic [31:0] m_frames;
  logic        m_err;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    assert (act === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_ts = '0; m_first = 1'b1; m_state = 2'd0;
    m_pkts = '0; m_frames = '0; m_err = 1'b0;
  endtask

  // Apply the receiver's rules to the beat currently on the bus.
  task automatic model_push();
    rec_t r;
    r.pc    = S_AXIS_tdata[63:0];
    r.delta = S_AXIS_tdata[127:64];
    r.instr = S_AXIS_tdata[159:128];
    r.ts    = m_first ? r.delta : m_ts + r.delta;
    r.last  = S_AXIS_tlast;
    r.wfi   = (r.instr == WFI_INSTRUCTION);
    if (!m_first && r.delta == 64'd0) m_err = 1'b1;
    m_first = 1'b0;
    m_ts    = r.ts;
    m_state = r.wfi ? 2'd2 : 2'd1;
    if (m_pkts != 32'hFFFF_FFFF) m_pkts = m_pkts + 32'd1;
    if (r.last && m_frames != 32'hFFFF_FFFF) m_frames = m_frames + 32'd1;
    exp_q.push_back(r);
  endtask

  // One clock: check at negedge, advance model, return at posedge+1.
  task automatic cycle(output bit acc);
    rec_t got;
    @(negedge clk);
    chk("tready", 256'(S_AXIS_tready), 256'((exp_q.size() < 2) && !clear));
    chk("out_valid", 256'(out_valid), 256'(exp_q.size() != 0));
    chk("state", 256'(state), 256'(m_state));
    chk("pkt_count", 256'(pkt_count), 256'(STATS_EN ? m_pkts : 32'd0));
    chk("frame_count", 256'(frame_count), 256'(STATS_EN ? m_frames : 32'd0));
    chk("delta_err", 256'(delta_err), 256'(STATS_EN ? m_err : 1'b0));
    if (exp_q.size() != 0) begin
      got.pc = out_pc; got.instr = out_instr; got.delta = out_delta;
      got.ts = out_timestamp; got.last = out_last; got.wfi = out_wfi;
      chk("record", 256'(got), 256'(exp_q[0]));
    end
    acc = S_AXIS_tvalid && (exp_q.size() < 2) && !clear;
    if (clear) begin
      model_reset();
    end else begin
      if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
      if (acc) model_push();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [63:0] pc, input logic [31:0] instr,
                       input logic [63:0] delta, input logic last);
    S_AXIS_tvalid = 1'b1;
    S_AXIS_tdata  = {instr, delta, pc};
    S_AXIS_tlast  = last;
  endtask

  task automatic send_beat(input logic [63:0] pc, input logic [31:0] instr,
                           input logic [63:0] delta, input logic last);
    bit acc;
    int budget;
    budget = 50;
    drive(pc, instr, delta, last);
    do begin
      cycle(acc);
      budget--;
    end while (!acc && budget > 0);
    chk("accept_timeout", 256'(acc), 256'(1'b1));
    S_AXIS_tvalid = 1'b0;
  endtask

  task automatic idle(input int n);
    bit acc;
    S_AXIS_tvalid = 1'b0;
    for (int i = 0; i < n; i++) cycle(acc);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_tready"}, 256'(S_AXIS_tready), 256'(1'b1));
    chk({tag, "_valid"}, 256'(out_valid), 256'(1'b0));
    chk({tag, "_data"}, 256'({out_pc, out_instr, out_delta, out_timestamp, out_last, out_wfi}), 256'(0));
    chk({tag, "_state"}, 256'(state), 256'(2'd0));
    chk({tag, "_stats"}, 256'({pkt_count, frame_count, delta_err}), 256'(0));
  endtask

  initial begin
    bit          acc;
    logic [63:0] ts_before;
    logic [63:0] rd;
    logic [31:0] ri;

    // Reset state
    model_reset();
    #12;
    chk_reset_vals("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Deltas 5, 1, 3 with a ready consumer
    out_ready = 1'b1;
    send_beat(64'h1000, NOP, 64'd5, 1'b0);
    chk("ts_5", 256'(out_timestamp), 256'(64'd5));
    send_beat(64'h1004, NOP, 64'd1, 1'b0);
    chk("ts_6", 256'(out_timestamp), 256'(64'd6));
    send_beat(64'h1008, NOP, 64'd3, 1'b0);
    chk("ts_9", 256'(out_timestamp), 256'(64'd9));
    chk("run_state", 256'(state), 256'(2'd1));
    chk("pkt_3", 256'(pkt_count), 256'(STATS_EN ? 32'd3 : 32'd0));
    chk("no_err", 256'(delta_err), 256'(1'b0));
    idle(2);

    // Back-pressure: only two of three back-to-back beats get in
    out_ready = 1'b0;
    drive(64'h2000, NOP, 64'd2, 1'b0); cycle(acc);
    drive(64'h2004, NOP, 64'd2, 1'b0); cycle(acc);
    chk("bp_tready_low", 256'(S_AXIS_tready), 256'(1'b0));
    drive(64'h2008, NOP, 64'd2, 1'b0); cycle(acc);
    cycle(acc);
    chk("bp_out_hold", 256'(out_pc), 256'(64'h2000));
    out_ready = 1'b1;
    cycle(acc);
    chk("bp_tready_back", 256'(S_AXIS_tready), 256'(1'b1));
    send_beat(64'h2008, NOP, 64'd2, 1'b0);
    idle(3);
    chk("bp_drained", 256'(out_valid), 256'(1'b0));

    // WFI ends the frame; the next beat resumes without re-basing
    send_beat(64'h3000, WFI_INSTRUCTION, 64'd7, 1'b1);
    chk("wfi_flag", 256'({out_wfi, out_last}), 256'(2'b11));
    chk("ended", 256'(state), 256'(2'd2));
    chk("frame_1", 256'(frame_count), 256'(STATS_EN ? 32'd1 : 32'd0));
    ts_before = out_timestamp;
    send_beat(64'h3004, NOP, 64'd4, 1'b0);
    chk("resume_run", 256'(state), 256'(2'd1));
    chk("resume_ts", 256'(out_timestamp), 256'(ts_before + 64'd4));
    idle(2);

    // Timestamp wrap
    clear = 1'b1; cycle(acc); clear = 1'b0;
    send_beat(64'h4000, NOP, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
    send_beat(64'h4004, NOP, 64'd3, 1'b0);
    chk("wrap_ts", 256'(out_timestamp), 256'(64'd1));
    chk("wrap_no_err", 256'(delta_err), 256'(1'b0));
    idle(2);

    // Zero delta on a later beat is sticky; clear wins over a beat
    clear = 1'b1; cycle(acc); clear = 1'b0;
    send_beat(64'h5000, NOP, 64'd9, 1'b0);
    send_beat(64'h5004, NOP, 64'd0, 1'b0);
    chk("err_set", 256'(delta_err), 256'(STATS_EN ? 1'b1 : 1'b0));
    send_beat(64'h5008, NOP, 64'd2, 1'b0);
    chk("err_sticky", 256'(delta_err), 256'(STATS_EN ? 1'b1 : 1'b0));
    out_ready = 1'b0;
    idle(1);
    drive(64'h500C, NOP, 64'd6, 1'b0);
    clear = 1'b1;
    cycle(acc);
    clear = 1'b0;
    S_AXIS_tvalid = 1'b0;
    chk("clr_valid", 256'(out_valid), 256'(1'b0));
    chk("clr_state", 256'(state), 256'(2'd0));
    chk("clr_stats", 256'({pkt_count, frame_count, delta_err}), 256'(0));
    out_ready = 1'b1;
    idle(2);

    // Random traffic with random back-pressure and occasional clear
    for (int i = 0; i < 400; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      clear     = ($urandom_range(0, 59) == 0);
      if (!S_AXIS_tvalid && $urandom_range(0, 3) != 0) begin
        case ($urandom_range(0, 9))
          0:       rd = 64'd0;
          1:       rd = {$urandom(), $urandom()};
          default: rd = 64'($urandom_range(1, 100));
        endcase
        ri = ($urandom_range(0, 5) == 0) ? WFI_INSTRUCTION : $urandom();
        drive({$urandom(), $urandom()}, ri, rd, ($urandom_range(0, 3) == 0));
      end
      cycle(acc);
      if (acc) S_AXIS_tvalid = 1'b0;
    end
    clear = 1'b0;
    out_ready = 1'b1;
    idle(4);

    // Asynchronous reset while the skid register is full
    out_ready = 1'b0;
    send_beat(64'h6000, NOP, 64'd11, 1'b0);
    send_beat(64'h6004, NOP, 64'd12, 1'b1);
    chk("skid_full", 256'(S_AXIS_tready), 256'(1'b0));
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("async");
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;

    // First beat after reset may carry delta 0
    send_beat(64'h7000, NOP, 64'd0, 1'b0);
    chk("post_rst_ts", 256'(out_timestamp), 256'(64'd0));
    chk("post_rst_err", 256'(delta_err), 256'(1'b0));
    chk("post_rst_pkt", 256'(pkt_count), 256'(STATS_EN ? 32'd1 : 32'd0));
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
